masked_sbox_pipe: RTL and testbench

- Parametrised, first-order 2-share AES S-box array: NUM_SBOX lanes of the three-register-stage masked S-box datapath.
- Adds what the bare S-box lacks: valid/ready flow control with backpressure, a randomness handshake, an occupancy count and async reset.
- Sits between the AES round-state mux and MixColumns/ShiftRows (NUM_SBOX=16) or in the key schedule (NUM_SBOX=4).

---
 rtl/masked_sbox_pkg.sv | 42 ++++
 rtl/masked_sbox_lane_ce.sv | 52 +++++
 rtl/masked_sbox_pipe.sv | 70 +++++++
 tb/tb_masked_sbox_pipe.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/masked_sbox_pkg.sv
// masked_sbox_pkg: shared constants, linear-map selectors and GF(2^8) share arithmetic
// for the first-order two-share AES S-box pipeline.
package masked_sbox_pkg;
    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam int         RND_PER_SBOX = 28;
    localparam int         SHARE_W      = 8;

    typedef enum logic [1:0] {FWD_IN, INV_IN, FWD_OUT, INV_OUT} map_e;
    typedef logic [1:0][SHARE_W-1:0] shares_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Squaring is linear over GF(2), so it is applied to each share separately.
    function automatic shares_t sh_pow2k(input shares_t s, input int k);
        shares_t y;
        y = s;
        for (int i = 0; i < k; i++) y = {gf_mul(y[1], y[1]), gf_mul(y[0], y[0])};
        return y;
    endfunction

    // Domain-oriented multiplication: cross terms are remasked with z.
    function automatic shares_t dom_mul(input shares_t a, input shares_t b, input logic [7:0] z);
        return {gf_mul(a[1], b[1]) ^ gf_mul(a[1], b[0]) ^ z,
                gf_mul(a[0], b[0]) ^ gf_mul(a[0], b[1]) ^ z};
    endfunction

    function automatic logic [7:0] lin_map(input map_e sel, input logic [7:0] x);
        logic [7:0] fwd, inv;
        fwd = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
        inv = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
        return sel == FWD_OUT ? fwd : sel == INV_IN ? inv : x;
    endfunction
endpackage

// File: rtl/masked_sbox_lane_ce.sv
// masked_sbox_lane_ce: one byte lane, x^254 inversion over two shares in three
// clock-enabled register stages with selectable input/output linear maps.
module masked_sbox_lane_ce
    import masked_sbox_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_ce,
    input  logic                    i_inv_in,
    input  logic                    i_inv_out,
    input  logic [SHARE_W-1:0]      i_sh0,
    input  logic [SHARE_W-1:0]      i_sh1,
    input  logic [RND_PER_SBOX-1:0] i_rnd,
    output logic [SHARE_W-1:0]      o_sh0,
    output logic [SHARE_W-1:0]      o_sh1
);
    map_e    w_in_sel, w_out_sel;
    shares_t w_a, w_x2, w_x3, w_x12, w_x14, w_x15, w_y;
    shares_t r1_x2, r1_x3, r2_x14, r2_x15;
    logic [SHARE_W-1:0] r3_sh0, r3_sh1;

    assign w_in_sel  = i_inv_in ? INV_IN : FWD_IN;
    assign w_out_sel = i_inv_out ? INV_OUT : FWD_OUT;
    assign w_a   = {lin_map(w_in_sel, i_sh1), lin_map(w_in_sel, i_sh0 ^ (i_inv_in ? AFFINE_C : 8'h00))};
    assign w_x2  = sh_pow2k(w_a, 1);
    assign w_x3  = dom_mul(w_a, w_x2, i_rnd[7:0]);
    assign w_x12 = sh_pow2k(r1_x3, 2);
    assign w_x15 = dom_mul(r1_x3, w_x12, i_rnd[15:8]);
    assign w_x14 = dom_mul(w_x12, r1_x2, i_rnd[23:16]);
    // x^240 * x^14 = x^254, the field inverse (0 maps to 0)
    assign w_y   = dom_mul(sh_pow2k(r2_x15, 4), r2_x14, {2{i_rnd[27:24]}});

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r1_x2  <= '0;
            r1_x3  <= '0;
            r2_x14 <= '0;
            r2_x15 <= '0;
            r3_sh0 <= '0;
            r3_sh1 <= '0;
        end else if (i_ce) begin
            r1_x2  <= w_x2;
            r1_x3  <= w_x3;
            r2_x14 <= w_x14;
            r2_x15 <= w_x15;
            r3_sh0 <= lin_map(w_out_sel, w_y[0]) ^ (i_inv_out ? 8'h00 : AFFINE_C);
            r3_sh1 <= lin_map(w_out_sel, w_y[1]);
        end

    assign o_sh0 = r3_sh0;
    assign o_sh1 = r3_sh1;
endmodule

// File: rtl/masked_sbox_pipe.sv
// masked_sbox_pipe: NUM_SBOX masked S-box lanes with valid/ready, randomness handshake
// and occupancy. MASKED_SBOX_INV_EN adds per-transaction inverse S-box selection.
module masked_sbox_pipe
    import masked_sbox_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_inv,
    input  logic [8*NUM_SBOX-1:0]            in_sh0,
    input  logic [8*NUM_SBOX-1:0]            in_sh1,
    input  logic [RND_PER_SBOX*NUM_SBOX-1:0] rnd,
    input  logic                             rnd_valid,
    output logic                             rnd_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [8*NUM_SBOX-1:0]            out_sh0,
    output logic [8*NUM_SBOX-1:0]            out_sh1,
    output logic [1:0]                       occupancy
);
    localparam int LATENCY = 3;

    logic [LATENCY-1:0] r_v;
    logic w_step, w_inv_in, w_inv_out;

    // Fresh randomness is burned on every step, bubbles included.
    assign w_step    = rnd_valid & (out_ready | ~r_v[LATENCY-1]) & ~RST;
    assign in_ready  = w_step;
    assign rnd_ready = w_step;
    assign out_valid = r_v[LATENCY-1];
    assign occupancy = {1'b0, r_v[0]} + {1'b0, r_v[1]} + {1'b0, r_v[2]};

    always_ff @(posedge CLK or posedge RST)
        if (RST) r_v <= '0;
        else if (w_step) r_v <= {r_v[LATENCY-2:0], in_valid};

`ifdef MASKED_SBOX_INV_EN
    logic [LATENCY-1:0] r_m;
    logic w_unused_m3;
    always_ff @(posedge CLK or posedge RST)
        if (RST) r_m <= '0;
        else if (w_step) r_m <= {r_m[LATENCY-2:0], in_inv};
    assign w_inv_in    = in_inv;
    assign w_inv_out   = r_m[1];
    assign w_unused_m3 = r_m[2];
`else
    logic w_unused_inv;
    assign w_inv_in     = 1'b0;
    assign w_inv_out    = 1'b0;
    assign w_unused_inv = in_inv;
`endif

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
        masked_sbox_lane_ce u_lane (
            .CLK       (CLK),
            .RST       (RST),
            .i_ce      (w_step),
            .i_inv_in  (w_inv_in),
            .i_inv_out (w_inv_out),
            .i_sh0     (in_sh0[8*k +: 8]),
            .i_sh1     (in_sh1[8*k +: 8]),
            .i_rnd     (rnd[RND_PER_SBOX*k +: RND_PER_SBOX]),
            .o_sh0     (out_sh0[8*k +: 8]),
            .o_sh1     (out_sh1[8*k +: 8])
        );
    end
endmodule

// File: tb/tb_masked_sbox_pipe.sv
// tb_masked_sbox_pipe: randomized bench with an S-box table model and a transaction
// queue that tracks acceptance, step counts and delivery order.
module tb_masked_sbox_pipe;
    localparam int N  = 4;
    localparam int W  = 8 * N;
    localparam int RW = 28 * N;

    logic          CLK, RST, in_valid, in_ready, in_inv, rnd_valid, rnd_ready;
    logic          out_valid, out_ready;
    logic [W-1:0]  in_sh0, in_sh1, out_sh0, out_sh1;
    logic [RW-1:0] rnd;
    logic [1:0]    occupancy;

    masked_sbox_pipe #(.NUM_SBOX(N)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_sh0(in_sh0), .in_sh1(in_sh1), .rnd(rnd), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sh0(out_sh0), .out_sh1(out_sh1), .occupancy(occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] exp;
        int           steps;
    } txn_t;

    txn_t       q[$];
    logic [7:0] sbox[256];
    logic [7:0] isbox[256];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv, b, c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return b;
    endfunction

    function automatic logic [W-1:0] expect_of(input logic [W-1:0] plain, input logic inv);
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) begin
`ifdef MASKED_SBOX_INV_EN
            r[8*k +: 8] = inv ? isbox[plain[8*k +: 8]] : sbox[plain[8*k +: 8]];
`else
            r[8*k +: 8] = sbox[plain[8*k +: 8]];
`endif
        end
        return r;
    endfunction

    // One clock: drive at negedge, check at negedge+1, update the model at posedge.
    task automatic tick(input logic v, input logic [W-1:0] plain, input logic [W-1:0] mask,
                        input logic inv, input logic [W-1:0] exp, input logic rv, input logic ordy);
        logic v3, st;
        in_valid  = v;
        in_sh0    = mask;
        in_sh1    = plain ^ mask;
        in_inv    = inv;
        rnd_valid = rv;
        out_ready = ordy;
        for (int i = 0; i < RW; i++) rnd[i] = 1'($urandom);
        #1;
        v3 = q.size() > 0 && q[0].steps == 3;
        st = rv && (ordy || !v3);
        check("in_ready", W'(in_ready), W'(st));
        check("rnd_ready", W'(rnd_ready), W'(st));
        check("out_valid", W'(out_valid), W'(v3));
        check("occupancy", W'(occupancy), W'(q.size()));
        if (v3) check("data", out_sh0 ^ out_sh1, q[0].exp);
        @(posedge CLK);
        if (st) begin
            if (v3) void'(q.pop_front());
            foreach (q[i]) q[i].steps++;
            if (v) q.push_back(txn_t'{exp: exp, steps: 1});
        end
        @(negedge CLK);
    endtask

    task automatic rand_tick(input logic v, input logic rv, input logic ordy);
        logic [W-1:0] p;
        logic         inv;
        p   = $urandom;
        inv = 1'($urandom);
        tick(v, p, $urandom, inv, expect_of(p, inv), rv, ordy);
    endtask

    initial begin
        logic [7:0] fwd_list[8];
        fwd_list = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5};
        for (int i = 0; i < 256; i++) sbox[i] = ref_sbox(8'(i));
        for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);

        RST = 1'b1; in_valid = 1'b1; in_inv = 1'b0; in_sh0 = '1; in_sh1 = '0;
        rnd = '1; rnd_valid = 1'b1; out_ready = 1'b1;
        #12;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_occupancy", W'(occupancy), '0);
        check("rst_in_ready", W'(in_ready), '0);
        check("rst_sh0", out_sh0, '0);
        check("rst_sh1", out_sh1, '0);
        @(negedge CLK);
        RST = 1'b0;

        tick(1, 32'h53535353, 32'hA5A5A5A5, 0, 32'hEDEDEDED, 1, 1);
        repeat (4) tick(0, 0, $urandom, 0, 0, 1, 1);

        for (int i = 0; i < 8; i++)
            tick(1, {4{8'(i)}}, $urandom, 0, {4{fwd_list[i]}}, 1, 1);
        repeat (4) tick(0, 0, $urandom, 0, 0, 1, 1);

        repeat (4) rand_tick(1, 1, 1);
        repeat (5) rand_tick(1, 1, 0);
        repeat (6) rand_tick(1, 1, 1);
        repeat (4) rand_tick(1, 0, 1);
        repeat (6) rand_tick(1, 1, 1);

        repeat (6) rand_tick(1, 1, 0);
        #2 RST = 1'b1;
        #1;
        check("arst_out_valid", W'(out_valid), '0);
        check("arst_occupancy", W'(occupancy), '0);
        check("arst_in_ready", W'(in_ready), '0);
        check("arst_sh0", out_sh0, '0);
        check("arst_sh1", out_sh1, '0);
        q.delete();
        @(negedge CLK);
        RST = 1'b0;
        rand_tick(1, 1, 1);
        repeat (4) rand_tick(0, 1, 1);

`ifdef MASKED_SBOX_INV_EN
        for (int i = 0; i < 6; i++)
            if (i % 2 == 0) tick(1, 32'hEDEDEDED, $urandom, 1, 32'h53535353, 1, 1);
            else            tick(1, 32'h00000000, $urandom, 0, 32'h63636363, 1, 1);
        repeat (4) tick(0, 0, $urandom, 0, 0, 1, 1);
`endif

        repeat (250) rand_tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                               1'($urandom_range(0, 3) != 0));
        repeat (6) rand_tick(0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
